fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Initiator side of the FPU Start/Busy/Done handshake. Buffers floating-point add/multiply requests from decode in a small FIFO and issues them to the FPU one at a time. Tracks each in-flight destination register itself, because the FPU does not return a usable write address. Captures the FPU result on Done, produces a one-cycle register-file write, and exports a pending-register scoreboard for hazard checks.

## Interface

Parameters:
- DEPTH, 4, request FIFO entries (power of two, ≥2)

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ReqValid  in  1  decode presents an FP request
- ReqOp  in  1  0 = add, 1 = multiply
- ReqA, ReqB  in  32  operands
- ReqWA3  in  4  destination register
- ReqReady  out  1  request accepted when ReqValid & ReqReady
- FPUStart  out  1  one-cycle start pulse
- FPUOp  out  1  operation for the issued request
- FPUOperand1, FPUOperand2  out  32  operands, held from Start until Done
- FPUWA3  out  4  destination tag driven to the FPU
- FPUBusy  in  1  FPU busy
- FPUDone  in  1  FPU result valid, one cycle
- FPUResult  in  32  FPU result
- WE  out  1  register-file write enable, one-cycle pulse
- WA  out  4  write address
- WD  out  32  write data
- Pending  out  16  bit r set while register r has a queued or in-flight write
- Empty  out  1  FIFO empty and FSM in IDLE
- Error  out  1  sticky timeout flag (see Configuration)

## Operation

- Reset (Reset = 0): FIFO empty, FSM in IDLE, Pending = 0, Error = 0. All outputs 0; Empty = 1.
- Enqueue:
  - ReqReady = !full & !Pending[ReqWA3]. A write-after-write to a pending register stalls decode.
  - On accept: push {ReqOp, ReqA, ReqB, ReqWA3} and set Pending[ReqWA3].
- FSM states: IDLE, ISSUE, WAIT, WB.
  - IDLE → ISSUE when the FIFO is non-empty and FPUBusy = 0. Pop the head into the issue registers.
  - ISSUE: FPUStart = 1 for exactly this cycle. Go to WAIT.
  - WAIT: stay until FPUDone. On FPUDone, capture FPUResult and go to WB. FPUBusy is ignored in WAIT, because the FPU may raise Busy a cycle after Start.
  - WB: WE = 1, WA = issued tag, WD = captured result. Clear Pending[WA]. Go to IDLE.
- Only one operation is in flight at a time. There is no back-to-back issue, so the minimum spacing between Starts is 4 cycles.
- FPUDone in IDLE, ISSUE or WB is spurious: ignored, no WE.
- Enqueue and WB clear in the same cycle, same register: cannot occur, because ReqReady is computed from the registered Pending, which is still set during WB.
- Enqueue and pop in the same cycle: both happen; the count is unchanged.
- FIFO pointers wrap modulo DEPTH. A separate count distinguishes full from empty.

## Timing

- Request accepted at cycle t, FIFO empty, FSM in IDLE, FPUBusy = 0 → IDLE→ISSUE transition at t+1, FPUStart high at t+2.
- FPUDone at cycle d → WE high at d+1, Pending bit clears at d+2 (registered).
- WA and WD are valid only while WE = 1. FPUOp, FPUOperand1/2 and FPUWA3 are stable from the ISSUE cycle through the WAIT exit.
- Reset asserted mid-operation: everything clears immediately (asynchronous). Any in-flight result is discarded; the FPU is reset by the same signal.

## Configuration

- FPU_ISSUE_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - If FPUDone is not seen within 255 cycles of entering WAIT: set Error (sticky until reset), clear Pending for the issued tag, no WE, return to IDLE.
- FPU_ISSUE_TIMEOUT_EN undefined: WAIT lasts indefinitely, Error is tied to 0, and no counter is instantiated.

## Test plan

- Single add: enqueue ReqOp=0, A=0x3F800000, B=0x40000000, WA3=5. FPU model returns 0x40400000 three cycles after Start. Expect: FPUStart at t+2, Pending[5] high from t+1, WE with WA=5, WD=0x40400000 one cycle after Done, then Pending[5] = 0.
- Fill and drain: enqueue DEPTH requests to registers 1..4 with FPUBusy forced high. Expect ReqReady = 0 when full, and no Start until Busy drops. Then four in-order writebacks, each Start ≥4 cycles apart.
- Hazard: enqueue WA3=7, then offer WA3=7 again. Expect ReqReady = 0 until the WB cycle for 7 has passed; the second request is accepted at d+2.
- Spurious Done: pulse FPUDone while IDLE. Expect no WE and Pending unchanged.
- Reset mid-WAIT: assert Reset = 0 during WAIT with 2 entries queued. Expect Pending = 0, Empty = 1 and all outputs 0 immediately. A Done after reset release produces no WE.
- With FPU_ISSUE_TIMEOUT_EN: withhold Done after Start for WA3=3. Expect Error = 1 and Pending[3] = 0 at 255 cycles, no WE, and the next queued entry issued afterwards.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// FPU Start/Busy/Done initiator: request FIFO, single-issue FSM, writeback and pending-register scoreboard.
// Optional FPU_ISSUE_TIMEOUT_EN adds a 255-cycle WAIT watchdog with a sticky Error flag.
module fpu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic        ReqOp,
  input  logic [31:0] ReqA,
  input  logic [31:0] ReqB,
  input  logic [3:0]  ReqWA3,
  output logic        ReqReady,
  output logic        FPUStart,
  output logic        FPUOp,
  output logic [31:0] FPUOperand1,
  output logic [31:0] FPUOperand2,
  output logic [3:0]  FPUWA3,
  input  logic        FPUBusy,
  input  logic        FPUDone,
  input  logic [31:0] FPUResult,
  output logic        WE,
  output logic [3:0]  WA,
  output logic [31:0] WD,
  output logic [15:0] Pending,
  output logic        Empty,
  output logic        Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [68:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q;
  logic [31:0]   a_q, b_q, res_q;
  logic [3:0]    tag_q;
  logic [15:0]   pend_q, pend_d;
  logic          push, pop, full, clr, tmo;

  assign full     = (cnt_q == CW'(DEPTH));
  assign ReqReady = !full && !pend_q[ReqWA3];
  assign push     = ReqValid && ReqReady;
  assign pop      = (state_q == S_IDLE) && (cnt_q != '0) && !FPUBusy;
  // Pending bit of the issued tag drops on writeback or on a timeout abort.
  assign clr      = (state_q == S_WB) || tmo;

`ifdef FPU_ISSUE_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       err_q;

  assign tmo   = (state_q == S_WAIT) && !FPUDone && (tmo_cnt_q == 8'd254);
  assign Error = err_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == S_WAIT) ? tmo_cnt_q + 8'd1 : '0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign Error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (FPUDone)  state_d = S_WB;
        else if (tmo) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (clr)  pend_d[tag_q]  = 1'b0;
    if (push) pend_d[ReqWA3] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= {ReqOp, ReqA, ReqB, ReqWA3};
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) begin
        rp_q <= rp_q + AW'(1);
        {op_q, a_q, b_q, tag_q} <= mem_q[rp_q];
      end
      if (state_q == S_WAIT && FPUDone) res_q <= FPUResult;
    end
  end

  assign FPUStart    = (state_q == S_ISSUE);
  assign FPUOp       = op_q;
  assign FPUOperand1 = a_q;
  assign FPUOperand2 = b_q;
  assign FPUWA3      = tag_q;
  assign WE          = (state_q == S_WB);
  assign WA          = WE ? tag_q : '0;
  assign WD          = WE ? res_q : '0;
  assign Pending     = pend_q;
  assign Empty       = (cnt_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl against a cycle-timeline model (request queue + pending set + FPU stub).
module tb_fpu_issue_ctrl;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        ReqValid, ReqOp;
  logic [31:0] ReqA, ReqB;
  logic [3:0]  ReqWA3;
  logic        ReqReady, FPUStart, FPUOp;
  logic [31:0] FPUOperand1, FPUOperand2;
  logic [3:0]  FPUWA3;
  logic        FPUBusy, FPUDone;
  logic [31:0] FPUResult;
  logic        WE;
  logic [3:0]  WA;
  logic [31:0] WD;
  logic [15:0] Pending;
  logic        Empty, Error;

  fpu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset),
    .ReqValid(ReqValid), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB), .ReqWA3(ReqWA3),
    .ReqReady(ReqReady),
    .FPUStart(FPUStart), .FPUOp(FPUOp), .FPUOperand1(FPUOperand1), .FPUOperand2(FPUOperand2),
    .FPUWA3(FPUWA3), .FPUBusy(FPUBusy), .FPUDone(FPUDone), .FPUResult(FPUResult),
    .WE(WE), .WA(WA), .WD(WD), .Pending(Pending), .Empty(Empty), .Error(Error)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
  } req_t;

  int n_tests = 0;
  int n_fail  = 0;

  req_t        q[$];
  req_t        infl;
  bit          infl_v;
  logic [15:0] pend;
  int          cyc, start_at, done_at, we_at;
  int          fpu_lat;
  bit          last_acc;
  int          last_we, acc_cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fpu_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return op ? a * b : a + b;
  endfunction

  task automatic model_reset();
    q.delete();
    infl_v   = 1'b0;
    pend     = '0;
    start_at = -1;
    done_at  = -1;
    we_at    = -1;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model across the posedge.
  task automatic step(input bit v, input logic [3:0] tag, input logic op,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit busy, input bit spur);
    bit   acc, pop, allow_spur;
    req_t e;
    @(negedge CLK);
    allow_spur = !infl_v || cyc == start_at || cyc == we_at;
    ReqValid  = v;
    ReqOp     = op;
    ReqA      = a;
    ReqB      = b;
    ReqWA3    = tag;
    FPUBusy   = busy;
    FPUDone   = (cyc == done_at) || (spur && allow_spur);
    FPUResult = (cyc == done_at) ? infl.res : $urandom;
    #1;
    if (cyc == start_at)
      done_at = cyc + ((fpu_lat == 0) ? int'($urandom_range(1, 6)) : fpu_lat);
    check("start", FPUStart, cyc == start_at);
    if (infl_v && cyc >= start_at && cyc <= done_at) begin
      check("issue_op",  FPUOp,       infl.op);
      check("issue_a",   FPUOperand1, infl.a);
      check("issue_b",   FPUOperand2, infl.b);
      check("issue_tag", FPUWA3,      infl.tag);
    end
    check("we", WE, cyc == we_at);
    if (cyc == we_at) begin
      check("wa", WA, infl.tag);
      check("wd", WD, infl.res);
      last_we = cyc;
    end
    check("pending", Pending, pend);
    check("ready", ReqReady, (q.size() < DEPTH) && !pend[tag]);
    check("empty", Empty, (q.size() == 0) && !infl_v);
    check("error", Error, 1'b0);
    acc = v && (q.size() < DEPTH) && !pend[tag];
    pop = !infl_v && (q.size() > 0) && !busy;
    if (cyc == done_at) we_at = cyc + 1;
    @(posedge CLK);
    if (cyc == we_at) begin
      pend[infl.tag] = 1'b0;
      infl_v = 1'b0;
    end
    if (pop) begin
      infl     = q.pop_front();
      infl_v   = 1'b1;
      start_at = cyc + 1;
    end
    if (acc) begin
      e.op = op; e.a = a; e.b = b; e.tag = tag; e.res = fpu_fn(op, a, b);
      q.push_back(e);
      pend[tag] = 1'b1;
      acc_cyc = cyc;
    end
    last_acc = acc;
    cyc++;
  endtask

  task automatic idle(input bit busy);
    step(1'b0, 4'($urandom), 1'($urandom), $urandom, $urandom, busy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q.size() != 0 || infl_v); i++) idle(1'b0);
  endtask

`ifdef FPU_ISSUE_TIMEOUT_EN
  int s_cyc, e_cyc;
  bit we_seen, got_next;
`endif

  initial begin
    Reset = 1'b0; ReqValid = 1'b0; ReqOp = 1'b0; ReqA = '0; ReqB = '0; ReqWA3 = '0;
    FPUBusy = 1'b0; FPUDone = 1'b0; FPUResult = '0;
    fpu_lat = 0; cyc = 0; last_we = -1; acc_cyc = -1; last_acc = 1'b0;
    model_reset();
    #1;
    check("rst_pending", Pending, 16'h0);
    check("rst_empty",   Empty,   1'b1);
    check("rst_start",   FPUStart, 1'b0);
    check("rst_we",      WE,      1'b0);
    check("rst_error",   Error,   1'b0);
    check("rst_opnd1",   FPUOperand1, 32'h0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;

    // Single add with a 3-cycle FPU
    fpu_lat = 3;
    step(1'b1, 4'd5, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    repeat (10) idle(1'b0);
    check("add_wd_seen", last_we, start_at + 4);

    // Fill with Busy held, then drain
    fpu_lat = 0;
    for (int i = 1; i <= DEPTH; i++)
      step(1'b1, 4'(i), 1'($urandom), $urandom, $urandom, 1'b1, 1'b0);
    step(1'b1, 4'd6, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
    check("full_blocks", last_acc, 1'b0);
    repeat (3) idle(1'b1);
    drain();

    // Spurious Done while IDLE with an entry parked behind Busy
    step(1'b1, 4'd11, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, $urandom, $urandom, 1'b1, 1'b1);
    drain();

    // WAW hazard on register 7
    step(1'b1, 4'd7, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
    check("haz_first", last_acc, 1'b1);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 4'd7, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
      if (last_acc) break;
    end
    check("haz_accepted", last_acc, 1'b1);
    check("haz_acc_cyc", acc_cyc, last_we + 1);
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 2) != 0, 4'($urandom), 1'($urandom), $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    drain();

    // Reset during WAIT with two entries queued
    fpu_lat = 40;
    step(1'b1, 4'd2, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, 4'd8, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    @(negedge CLK);
    ReqValid = 1'b0; FPUDone = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_pending", Pending, 16'h0);
    check("mid_rst_empty",   Empty,   1'b1);
    check("mid_rst_start",   FPUStart, 1'b0);
    check("mid_rst_we",      WE,      1'b0);
    check("mid_rst_wa3",     FPUWA3,  4'h0);
    check("mid_rst_opnd2",   FPUOperand2, 32'h0);
    model_reset();
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    fpu_lat = 0;
    step(1'b0, 4'd0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
    repeat (3) idle(1'b0);

`ifdef FPU_ISSUE_TIMEOUT_EN
    fpu_lat = 100000;
    step(1'b1, 4'd3, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    s_cyc = -1; e_cyc = -1; we_seen = 1'b0; got_next = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      ReqValid = 1'b0; FPUDone = 1'b0; FPUBusy = 1'b0;
      #1;
      if (FPUStart && s_cyc < 0) s_cyc = k;
      if (WE) we_seen = 1'b1;
      if (Error) begin
        e_cyc = k;
        break;
      end
    end
    check("to_error", Error, 1'b1);
    check("to_pend3", Pending[3], 1'b0);
    check("to_no_we", we_seen, 1'b0);
    check("to_delay", e_cyc - s_cyc, 256);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      #1;
      if (FPUStart) begin
        got_next = 1'b1;
        check("to_next_tag", FPUWA3, 4'd9);
        break;
      end
    end
    check("to_next_issued", got_next, 1'b1);
    @(negedge CLK);
    Reset = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    fpu_lat = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
